// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: bundle of the arbitration and split signals between the
// master interfaces / address decoder / split-capable slaves and the arbiter.
//   mreq        : per-master bus request (level)
//   sel_slave   : decoder slave index for the current owner's transaction
//   ssplit      : per-slave split flag
//   mgrant      : one-hot master grant
//   owner       : index of the granted master (bus mux select)
//   msplit      : master parked by a split
//   split_grant : one-hot resume grant to the split slave
//   split_err   : sticky double-split flag
// Modports: master = requester/decoder/slave side, slave = arbiter side.
interface bus_arbiter_if #(
  parameter int NM = 2,
  parameter int NS = 3,
  parameter int MW = $clog2(NM),
  parameter int SW = $clog2(NS)
) ();
  logic [NM-1:0] mreq;
  logic [SW-1:0] sel_slave;
  logic [NS-1:0] ssplit;
  logic [NM-1:0] mgrant;
  logic [MW-1:0] owner;
  logic [NM-1:0] msplit;
  logic [NS-1:0] split_grant;
  logic          split_err;

  modport master (
    output mreq, sel_slave, ssplit,
    input  mgrant, owner, msplit, split_grant, split_err
  );

  modport slave (
    input  mreq, sel_slave, ssplit,
    output mgrant, owner, msplit, split_grant, split_err
  );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter for NM masters with split-transaction
// support. A slave raising ssplit parks the owning master and frees the bus;
// lowering ssplit returns the bus to the parked master ahead of all other
// requests, together with split_grant to that slave.
// Ports:
//   clk : bus clock
//   rst : synchronous active-high reset
//   bus : bus_arbiter_if.slave (mreq/sel_slave/ssplit in, grants/flags out)
module bus_arbiter #(
  parameter int NM = 2,
  parameter int NS = 3,
  parameter int MW = $clog2(NM),
  parameter int SW = $clog2(NS)
) (
  input  logic            clk,
  input  logic            rst,
  bus_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, BUSY, RESUME} state_t;

  state_t        state_q, state_d;
  logic [NM-1:0] mgrant_q, mgrant_d;
  logic [NM-1:0] msplit_q, msplit_d;
  logic [MW-1:0] owner_q, owner_d;
  logic [MW-1:0] rr_q, rr_d;
  logic [NS-1:0] split_grant_q, split_grant_d;
  logic          split_err_q, split_err_d;
  logic          split_valid_q, split_valid_d;
  logic          split_ready_q, split_ready_d;
  logic [MW-1:0] split_master_q, split_master_d;
  logic [SW-1:0] split_slave_q, split_slave_d;
  logic [NS-1:0] ss_prev_q;

  logic [NS-1:0] rise, fall;
  logic [NM-1:0] eligible;
  logic          sel_rise;
  logic          cancel;
  logic          found;
  logic [MW-1:0] owner_next;
  logic [MW-1:0] cand;
  int unsigned   idx;

  always_comb begin
    rise     = bus.ssplit & ~ss_prev_q;
    fall     = ~bus.ssplit & ss_prev_q;
    eligible = bus.mreq & ~msplit_q;
    sel_rise = (int'(bus.sel_slave) < NS) ? rise[bus.sel_slave] : 1'b0;
    // A parked master that withdraws its request abandons the split; this
    // also blocks a resume that would otherwise fire in the same cycle.
    cancel   = split_valid_q && (state_q != RESUME) && !bus.mreq[split_master_q];
    owner_next = (owner_q == MW'(NM - 1)) ? '0 : owner_q + 1'b1;

    state_d        = state_q;
    mgrant_d       = mgrant_q;
    msplit_d       = msplit_q;
    owner_d        = owner_q;
    rr_d           = rr_q;
    split_grant_d  = split_grant_q;
    split_err_d    = split_err_q;
    split_valid_d  = split_valid_q;
    split_ready_d  = split_ready_q;
    split_master_d = split_master_q;
    split_slave_d  = split_slave_q;
    found          = 1'b0;
    idx            = 0;
    cand           = '0;

    if (split_valid_q && fall[split_slave_q]) begin
      split_ready_d = 1'b1;
    end
    if (cancel) begin
      split_valid_d = 1'b0;
      split_ready_d = 1'b0;
      msplit_d      = '0;
    end

    case (state_q)
      IDLE: begin
        mgrant_d      = '0;
        split_grant_d = '0;
        if (split_valid_q && split_ready_q && !cancel) begin
          state_d                       = RESUME;
          mgrant_d[split_master_q]      = 1'b1;
          owner_d                       = split_master_q;
          split_grant_d[split_slave_q]  = 1'b1;
          msplit_d[split_master_q]      = 1'b0;
        end else begin
          for (int unsigned i = 0; i < NM; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= NM) begin
              idx = idx - NM;
            end
            cand = MW'(idx);
            if (!found && eligible[cand]) begin
              found          = 1'b1;
              mgrant_d[cand] = 1'b1;
              owner_d        = cand;
              state_d        = BUSY;
            end
          end
        end
      end

      BUSY: begin
        if (sel_rise) begin
          mgrant_d = '0;
          state_d  = IDLE;
          if (!split_valid_q) begin
            split_valid_d     = 1'b1;
            split_master_d    = owner_q;
            split_slave_d     = bus.sel_slave;
            split_ready_d     = 1'b0;
            msplit_d[owner_q] = 1'b1;
          end else begin
            // Only one split can be tracked: flag it and end this ownership.
            split_err_d = 1'b1;
            rr_d        = owner_next;
          end
        end else if (!bus.mreq[owner_q]) begin
          mgrant_d = '0;
          rr_d     = owner_next;
          state_d  = IDLE;
        end
      end

      RESUME: begin
        if (!bus.mreq[split_master_q]) begin
          mgrant_d      = '0;
          split_grant_d = '0;
          split_valid_d = 1'b0;
          split_ready_d = 1'b0;
          state_d       = IDLE;
        end
      end

      default: begin
        mgrant_d      = '0;
        split_grant_d = '0;
        state_d       = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      mgrant_q       <= '0;
      msplit_q       <= '0;
      owner_q        <= '0;
      rr_q           <= '0;
      split_grant_q  <= '0;
      split_err_q    <= 1'b0;
      split_valid_q  <= 1'b0;
      split_ready_q  <= 1'b0;
      split_master_q <= '0;
      split_slave_q  <= '0;
      ss_prev_q      <= '0;
    end else begin
      state_q        <= state_d;
      mgrant_q       <= mgrant_d;
      msplit_q       <= msplit_d;
      owner_q        <= owner_d;
      rr_q           <= rr_d;
      split_grant_q  <= split_grant_d;
      split_err_q    <= split_err_d;
      split_valid_q  <= split_valid_d;
      split_ready_q  <= split_ready_d;
      split_master_q <= split_master_d;
      split_slave_q  <= split_slave_d;
      ss_prev_q      <= bus.ssplit;
    end
  end

  assign bus.mgrant      = mgrant_q;
  assign bus.owner       = owner_q;
  assign bus.msplit      = msplit_q;
  assign bus.split_grant = split_grant_q;
  assign bus.split_err   = split_err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed test of bus_arbiter (NM=2, NS=3) covering reset,
// single request, round-robin, split/resume, resume priority, split cancel,
// double split and reset during resume.
module tb_bus_arbiter;
  localparam int NM = 2;
  localparam int NS = 3;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  bus_arbiter_if #(.NM(NM), .NS(NS)) bif ();

  bus_arbiter #(.NM(NM), .NS(NS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] g, input logic [1:0] ms,
                         input logic [2:0] sg);
    chk({tag, "_mgrant"}, 32'(bif.mgrant), 32'(g));
    chk({tag, "_msplit"}, 32'(bif.msplit), 32'(ms));
    chk({tag, "_split_grant"}, 32'(bif.split_grant), 32'(sg));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bif.mreq = 2'b00;
    bif.sel_slave = 2'd0;
    bif.ssplit = 3'b000;
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk_all("reset", 2'b00, 2'b00, 3'b000);
    chk("reset_owner", 32'(bif.owner), 32'd0);
    chk("reset_err", 32'(bif.split_err), 32'd0);

    // Single request: granted one cycle later, held 5 cycles, dropped on release
    bif.mreq = 2'b01;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("single_grant", 32'(bif.mgrant), 32'h1);
      chk("single_owner", 32'(bif.owner), 32'd0);
    end
    bif.mreq = 2'b00;
    step();
    chk("single_release", 32'(bif.mgrant), 32'h0);

    // Round-robin from a fresh pointer
    rst = 1'b1;
    step();
    rst = 1'b0;
    bif.mreq = 2'b11;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rr_m0", 32'(bif.mgrant), 32'h1);
    end
    bif.mreq = 2'b10;
    step();
    chk("rr_gap0", 32'(bif.mgrant), 32'h0);
    bif.mreq = 2'b11;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rr_m1", 32'(bif.mgrant), 32'h2);
      chk("rr_m1_owner", 32'(bif.owner), 32'd1);
    end
    bif.mreq = 2'b01;
    step();
    chk("rr_gap1", 32'(bif.mgrant), 32'h0);
    bif.mreq = 2'b11;
    step();
    chk("rr_back_m0", 32'(bif.mgrant), 32'h1);
    bif.mreq = 2'b00;
    step();
    chk("rr_release", 32'(bif.mgrant), 32'h0);

    // Split and resume
    rst = 1'b1;
    step();
    rst = 1'b0;
    bif.mreq = 2'b01;
    bif.sel_slave = 2'd2;
    step();
    chk("split_pre", 32'(bif.mgrant), 32'h1);
    bif.ssplit = 3'b100;
    step();
    chk_all("split_park", 2'b00, 2'b01, 3'b000);
    bif.mreq = 2'b11;
    step();
    chk_all("split_m1", 2'b10, 2'b01, 3'b000);
    chk("split_m1_owner", 32'(bif.owner), 32'd1);
    bif.ssplit = 3'b000;
    step();
    chk("split_m1_hold", 32'(bif.mgrant), 32'h2);
    bif.mreq = 2'b01;
    step();
    chk("split_m1_rel", 32'(bif.mgrant), 32'h0);
    step();
    chk_all("resume", 2'b01, 2'b00, 3'b100);
    chk("resume_owner", 32'(bif.owner), 32'd0);
    step();
    chk_all("resume_hold", 2'b01, 2'b00, 3'b100);
    bif.mreq = 2'b00;
    step();
    chk_all("resume_end", 2'b00, 2'b00, 3'b000);

    // Resume priority: pointer favours M1, yet the resumed M0 goes first
    bif.mreq = 2'b01;
    step();
    chk("prio_g0", 32'(bif.mgrant), 32'h1);
    bif.mreq = 2'b00;
    step();
    bif.mreq = 2'b01;
    step();
    chk("prio_g0b", 32'(bif.mgrant), 32'h1);
    bif.ssplit = 3'b100;
    step();
    chk_all("prio_park", 2'b00, 2'b01, 3'b000);
    bif.ssplit = 3'b000;
    step();
    chk("prio_idle", 32'(bif.mgrant), 32'h0);
    bif.mreq = 2'b11;
    step();
    chk_all("prio_resume", 2'b01, 2'b00, 3'b100);
    step();
    chk("prio_hold", 32'(bif.mgrant), 32'h1);
    bif.mreq = 2'b10;
    step();
    chk_all("prio_rel", 2'b00, 2'b00, 3'b000);
    step();
    chk("prio_m1", 32'(bif.mgrant), 32'h2);
    bif.mreq = 2'b00;
    step();

    // Split cancel
    bif.mreq = 2'b01;
    step();
    chk("cancel_g0", 32'(bif.mgrant), 32'h1);
    bif.ssplit = 3'b100;
    step();
    chk("cancel_park", 32'(bif.msplit), 32'h1);
    bif.mreq = 2'b00;
    step();
    chk("cancel_msplit", 32'(bif.msplit), 32'h0);
    bif.ssplit = 3'b000;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("cancel_quiet", 2'b00, 2'b00, 3'b000);
    end
    bif.mreq = 2'b01;
    step();
    chk_all("cancel_fresh", 2'b01, 2'b00, 3'b000);
    bif.mreq = 2'b00;
    step();

    // Double split, then reset in the middle of RESUME
    bif.mreq = 2'b01;
    bif.sel_slave = 2'd2;
    step();
    chk("dbl_g0", 32'(bif.mgrant), 32'h1);
    bif.ssplit = 3'b100;
    step();
    chk("dbl_park", 32'(bif.msplit), 32'h1);
    bif.mreq = 2'b11;
    bif.sel_slave = 2'd1;
    step();
    chk("dbl_m1", 32'(bif.mgrant), 32'h2);
    bif.ssplit = 3'b110;
    step();
    chk("dbl_err", 32'(bif.split_err), 32'd1);
    chk_all("dbl_drop", 2'b00, 2'b01, 3'b000);
    step();
    chk("dbl_regrant", 32'(bif.mgrant), 32'h2);
    chk("dbl_err_sticky", 32'(bif.split_err), 32'd1);
    bif.ssplit = 3'b010;
    step();
    bif.mreq = 2'b01;
    step();
    chk("dbl_m1_rel", 32'(bif.mgrant), 32'h0);
    step();
    chk_all("dbl_resume", 2'b01, 2'b00, 3'b100);
    rst = 1'b1;
    step();
    chk_all("rst_mid", 2'b00, 2'b00, 3'b000);
    chk("rst_mid_owner", 32'(bif.owner), 32'd0);
    chk("rst_mid_err", 32'(bif.split_err), 32'd0);
    rst = 1'b0;
    bif.mreq = 2'b00;
    bif.ssplit = 3'b000;
    step();
    chk("rst_idle", 32'(bif.mgrant), 32'h0);
    bif.mreq = 2'b10;
    step();
    chk("rst_after_grant", 32'(bif.mgrant), 32'h2);
    chk("rst_after_owner", 32'(bif.owner), 32'd1);
    bif.mreq = 2'b00;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
